ifu_fetch_requester: RTL and testbench
======================================

Name: ifu_fetch_requester

Overview:
- Initiator side of the IFU instruction-cache burst interface.
- Holds the fetch PC and issues block requests of FETCH_COUNT instructions to the cache.
- Unpacks the returned 128-bit bursts into an instruction/PC queue and presents one instruction per cycle downstream with valid/ready.
- Handles redirects (branch/flush): drops stale queue contents and drains any in-flight cache transaction.

Parameters:
- FETCH_COUNT, 4, instructions requested per cache transaction; legal range 1..7.
- QUEUE_DEPTH, 8, instruction queue entries; power of two, >= FETCH_COUNT.
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- fetch_enable_in  input  1  permits new cache requests
- redirect_valid_in  input  1  one-cycle redirect/flush strobe
- redirect_pc_in  input  32  redirect target; bits [1:0] ignored, treated as 0
- cache_addr_out  output  32  request block PC, word aligned
- cache_request_out  output  1  one-cycle request strobe
- ins_count_out  output  3  instructions requested, constant FETCH_COUNT
- cache_rdata_in  input  128  burst data; lane i = bits [32i+31:32i], lane 0 = lowest PC
- cache_rvalid_in  input  1  burst valid, one cycle per burst
- cache_burst_done_in  input  1  transaction complete, one cycle, arrives after the final rvalid
- instr_out  output  32  head-of-queue instruction
- instr_pc_out  output  32  PC of instr_out
- instr_valid_out  output  1  queue not empty
- instr_ready_in  input  1  consumer accepts the head when valid & ready
- queue_count_out  output  $clog2(QUEUE_DEPTH)+1  occupied entries
- fetch_busy_out  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, fetch_pc=RESET_PC, queue empty. All outputs 0, except cache_addr_out = RESET_PC and ins_count_out = FETCH_COUNT.
- State machine: IDLE, REQ, WAIT_DATA, DISCARD. cache_request_out is registered and high only in REQ.
- IDLE -> REQ when fetch_enable_in=1, redirect_valid_in=0, and (QUEUE_DEPTH - queue_count) >= FETCH_COUNT.
  - Free space is checked with the post-pop count of the same cycle.
  - The reserved space guarantees a queue push can never overflow.
- REQ: one cycle.
  - Drives cache_addr_out = fetch_pc and cache_request_out = 1.
  - Latches burst_pc = fetch_pc and remaining = FETCH_COUNT.
  - Advances fetch_pc by 4*FETCH_COUNT, 32-bit wraparound.
  - Goes to WAIT_DATA.
- WAIT_DATA, per cycle with cache_rvalid_in=1:
  - n = min(4, remaining).
  - Push lanes 0..n-1 in lane order with PC = burst_pc + 4*i.
  - burst_pc += 4n; remaining -= n.
  - Lanes >= n are ignored.
- WAIT_DATA -> IDLE on cache_burst_done_in. The next REQ is no earlier than the following cycle.
- No cache latency is assumed; arbitrary gaps between bursts are tolerated. rvalid/done seen in IDLE or REQ are ignored.
- Queue timing:
  - Pushed entries are visible on instr_out the cycle after the rvalid cycle.
  - Simultaneous push of up to 4 and pop of 1 is supported; count updates by pushes - pop.
- Redirect (redirect_valid_in=1), any state:
  - Queue flushed; count=0 next cycle. A pop in the same cycle is discarded, as is any push from a same-cycle rvalid.
  - fetch_pc <= {redirect_pc_in[31:2],2'b00}.
  - IDLE: stays IDLE.
  - REQ: the request is still presented this cycle; go to DISCARD.
  - WAIT_DATA: go to DISCARD.
  - DISCARD: stay in DISCARD; latest target wins.
- DISCARD: all rvalid bursts are dropped. On cache_burst_done_in -> IDLE. Redirect has priority over a same-cycle done: fetch_pc is updated and the transition is still taken.
- fetch_enable_in deassertion never aborts an in-flight transaction.
- Reset mid-transaction returns to reset values. The environment resets the cache in the same cycle.

Test Plan:
- Cache image word k = k<<2, so instruction value equals its PC. Reset, enable, ready=1, FETCH_COUNT=4:
  - One request with addr 0x00, ins_count_out 4.
  - One burst.
  - Output sequence (instr,pc) = (0x00,0x00), (0x04,0x04), (0x08,0x08), (0x0C,0x0C) on consecutive cycles.
  - Next request addr 0x10.
- FETCH_COUNT=7, ready=1:
  - Two bursts, of 4 then 3 instructions; lane 3 of the second burst is ignored.
  - Seven outputs 0x00..0x18.
  - Next addr 0x1C.
- QUEUE_DEPTH=8, ready=0:
  - Exactly two requests (0x00, 0x10); queue_count_out=8; no third request.
  - Raise ready for one cycle: still no request until free space >= 4.
- Redirect to 0x40 in the cycle after cache_request_out:
  - The in-flight burst is dropped; instr_valid_out stays 0.
  - The next request follows burst_done by >= 1 cycle with addr 0x40.
  - First output pc 0x40.
- Redirect coincident with rvalid in WAIT_DATA while the queue holds 3 entries and a pop occurs:
  - queue_count_out=0 next cycle; no burst entries appear.
- Reset asserted mid-WAIT_DATA: all outputs return to reset values the next cycle; the first request after release uses addr RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_requester.sv
// IFU fetch requester: issues FETCH_COUNT-instruction block reads to the I-cache,
// unpacks returned 128-bit bursts into an instruction/PC queue, and handles redirects.
module ifu_fetch_requester #(
    parameter int unsigned FETCH_COUNT = 4,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fetch_enable_in,
    input  logic                             redirect_valid_in,
    input  logic [31:0]                      redirect_pc_in,
    output logic [31:0]                      cache_addr_out,
    output logic                             cache_request_out,
    output logic [2:0]                       ins_count_out,
    input  logic [127:0]                     cache_rdata_in,
    input  logic                             cache_rvalid_in,
    input  logic                             cache_burst_done_in,
    output logic [31:0]                      instr_out,
    output logic [31:0]                      instr_pc_out,
    output logic                             instr_valid_out,
    input  logic                             instr_ready_in,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count_out,
    output logic                             fetch_busy_out
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        burst_pc_q, burst_pc_d;
    logic [2:0]         remaining_q, remaining_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        instr_mem_q [QUEUE_DEPTH];
    logic [31:0]        pc_mem_q    [QUEUE_DEPTH];

    logic               pop;
    logic               push;
    logic [2:0]         push_n;
    logic [CNT_W-1:0]   post_pop_cnt;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_in[1:0];

    always_comb begin
        pop          = (count_q != '0) && instr_ready_in && !redirect_valid_in;
        push         = (state_q == WAIT_DATA) && cache_rvalid_in && !redirect_valid_in;
        push_n       = (remaining_q > 3'd4) ? 3'd4 : remaining_q;
        post_pop_cnt = count_q - CNT_W'(pop);

        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        burst_pc_d  = burst_pc_q;
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(push_n) : wr_ptr_q;
        count_d     = post_pop_cnt + (push ? CNT_W'(push_n) : '0);

        if (push) begin
            burst_pc_d  = burst_pc_q + {27'b0, push_n, 2'b00};
            remaining_d = remaining_q - push_n;
        end

        case (state_q)
            IDLE: begin
                // Reserve room for the whole block up front so pushes never overflow.
                if (fetch_enable_in && !redirect_valid_in &&
                    ((CNT_W'(QUEUE_DEPTH) - post_pop_cnt) >= CNT_W'(FETCH_COUNT)))
                    state_d = REQ;
            end
            REQ: begin
                burst_pc_d  = fetch_pc_q;
                remaining_d = 3'(FETCH_COUNT);
                fetch_pc_d  = fetch_pc_q + 32'(4 * FETCH_COUNT);
                state_d     = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (cache_burst_done_in)
                    state_d = IDLE;
            end
            DISCARD: begin
                if (cache_burst_done_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid_in) begin
            fetch_pc_d = {redirect_pc_in[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A transaction that completes in the redirect cycle needs no draining.
            if (state_q == REQ)
                state_d = DISCARD;
            else if (state_q == WAIT_DATA && !cache_burst_done_in)
                state_d = DISCARD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            burst_pc_q  <= RESET_PC;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            burst_pc_q  <= burst_pc_d;
            remaining_q <= remaining_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push && (3'(i) < push_n)) begin
                instr_mem_q[wr_ptr_q + PTR_W'(i)] <= cache_rdata_in[32*i +: 32];
                pc_mem_q[wr_ptr_q + PTR_W'(i)]    <= burst_pc_q + {28'b0, 2'(i), 2'b00};
            end
        end
    end

    assign cache_addr_out    = fetch_pc_q;
    assign cache_request_out = (state_q == REQ);
    assign ins_count_out     = 3'(FETCH_COUNT);
    assign instr_valid_out   = (count_q != '0);
    assign instr_out         = instr_valid_out ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign instr_pc_out      = instr_valid_out ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign queue_count_out   = count_q;
    assign fetch_busy_out    = (state_q != IDLE);

endmodule

// File: tb/tb_ifu_fetch_requester.sv
// Directed bench for ifu_fetch_requester: one instance with FETCH_COUNT=4, one with 7.
module tb_ifu_fetch_requester;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FETCH_COUNT = 4 instance
    logic         a_en = 0, a_rv = 0, a_rvalid = 0, a_done = 0, a_ready = 0;
    logic [31:0]  a_rpc = 0;
    logic [127:0] a_rdata = 0;
    logic [31:0]  a_addr, a_instr, a_ipc;
    logic         a_req, a_ivld, a_busy;
    logic [2:0]   a_icnt;
    logic [3:0]   a_qcnt;

    // FETCH_COUNT = 7 instance
    logic         b_en = 0, b_rv = 0, b_rvalid = 0, b_done = 0, b_ready = 0;
    logic [31:0]  b_rpc = 0;
    logic [127:0] b_rdata = 0;
    logic [31:0]  b_addr, b_instr, b_ipc;
    logic         b_req, b_ivld, b_busy;
    logic [2:0]   b_icnt;
    logic [3:0]   b_qcnt;

    ifu_fetch_requester #(.FETCH_COUNT(4), .QUEUE_DEPTH(8), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(rst), .fetch_enable_in(a_en),
        .redirect_valid_in(a_rv), .redirect_pc_in(a_rpc),
        .cache_addr_out(a_addr), .cache_request_out(a_req), .ins_count_out(a_icnt),
        .cache_rdata_in(a_rdata), .cache_rvalid_in(a_rvalid), .cache_burst_done_in(a_done),
        .instr_out(a_instr), .instr_pc_out(a_ipc), .instr_valid_out(a_ivld),
        .instr_ready_in(a_ready), .queue_count_out(a_qcnt), .fetch_busy_out(a_busy)
    );

    ifu_fetch_requester #(.FETCH_COUNT(7), .QUEUE_DEPTH(8), .RESET_PC(32'h0)) u_dut7 (
        .clk(clk), .reset(rst), .fetch_enable_in(b_en),
        .redirect_valid_in(b_rv), .redirect_pc_in(b_rpc),
        .cache_addr_out(b_addr), .cache_request_out(b_req), .ins_count_out(b_icnt),
        .cache_rdata_in(b_rdata), .cache_rvalid_in(b_rvalid), .cache_burst_done_in(b_done),
        .instr_out(b_instr), .instr_pc_out(b_ipc), .instr_valid_out(b_ivld),
        .instr_ready_in(b_ready), .queue_count_out(b_qcnt), .fetch_busy_out(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_req",   {31'b0, a_req},  32'h0);
        chk("rst_addr",  a_addr,          32'h0);
        chk("rst_icnt",  {29'b0, a_icnt}, 32'h4);
        chk("rst_vld",   {31'b0, a_ivld}, 32'h0);
        chk("rst_qcnt",  {28'b0, a_qcnt}, 32'h0);
        chk("rst_busy",  {31'b0, a_busy}, 32'h0);
        chk("rst_instr", a_instr,         32'h0);
        chk("rst_icnt7", {29'b0, b_icnt}, 32'h7);

        // Basic fetch of one block, consumer always ready
        rst = 0; a_en = 1; a_ready = 1;
        tick();
        chk("t1_req",  {31'b0, a_req},  32'h1);
        chk("t1_addr", a_addr,          32'h0);
        chk("t1_busy", {31'b0, a_busy}, 32'h1);
        a_en = 0;
        tick();
        chk("t1_req_one_cycle", {31'b0, a_req}, 32'h0);
        a_rvalid = 1; a_rdata = {32'h0C, 32'h08, 32'h04, 32'h00};
        tick();
        chk("t1_i0",   a_instr,         32'h00);
        chk("t1_p0",   a_ipc,           32'h00);
        chk("t1_qcnt", {28'b0, a_qcnt}, 32'h4);
        a_rvalid = 0; a_done = 1;
        tick();
        chk("t1_i1", a_instr, 32'h04);
        chk("t1_p1", a_ipc,   32'h04);
        a_done = 0;
        tick();
        chk("t1_i2", a_instr, 32'h08);
        tick();
        chk("t1_i3", a_instr, 32'h0C);
        chk("t1_p3", a_ipc,   32'h0C);
        a_en = 1;
        tick();
        chk("t1_empty",  {31'b0, a_ivld}, 32'h0);
        chk("t1_req2",   {31'b0, a_req},  32'h1);
        chk("t1_addr2",  a_addr,          32'h10);

        // Reset in the middle of WAIT_DATA with a non-empty queue
        a_en = 0; a_ready = 0;
        tick();
        a_rvalid = 1; a_rdata = {32'h1C, 32'h18, 32'h14, 32'h10};
        tick();
        chk("rm_qcnt_pre", {28'b0, a_qcnt}, 32'h4);
        chk("rm_instr_pre", a_instr,        32'h10);
        rst = 1; a_rvalid = 0;
        tick();
        chk("rm_qcnt",  {28'b0, a_qcnt}, 32'h0);
        chk("rm_vld",   {31'b0, a_ivld}, 32'h0);
        chk("rm_instr", a_instr,         32'h0);
        chk("rm_pc",    a_ipc,           32'h0);
        chk("rm_busy",  {31'b0, a_busy}, 32'h0);
        chk("rm_addr",  a_addr,          32'h0);
        rst = 0; a_en = 1;
        tick();
        chk("rm_req",  {31'b0, a_req}, 32'h1);
        chk("rm_addr2", a_addr,        32'h0);

        // Queue fills with consumer stalled: exactly two requests
        tick();
        a_rvalid = 1; a_rdata = {32'h0C, 32'h08, 32'h04, 32'h00};
        tick();
        a_rvalid = 0; a_done = 1;
        tick();
        chk("qf_qcnt4", {28'b0, a_qcnt}, 32'h4);
        a_done = 0;
        tick();
        chk("qf_req2",  {31'b0, a_req}, 32'h1);
        chk("qf_addr2", a_addr,         32'h10);
        tick();
        a_rvalid = 1; a_rdata = {32'h1C, 32'h18, 32'h14, 32'h10};
        tick();
        a_rvalid = 0; a_done = 1;
        tick();
        a_done = 0;
        tick();
        chk("qf_qcnt8", {28'b0, a_qcnt}, 32'h8);
        chk("qf_noreq", {31'b0, a_req},  32'h0);
        tick();
        chk("qf_noreq2", {31'b0, a_req}, 32'h0);
        a_ready = 1;
        tick();
        chk("qf_qcnt7",  {28'b0, a_qcnt}, 32'h7);
        chk("qf_head",   a_instr,         32'h04);
        chk("qf_noreq3", {31'b0, a_req},  32'h0);
        a_ready = 0;
        tick();
        chk("qf_noreq4", {31'b0, a_req},  32'h0);
        chk("qf_busy",   {31'b0, a_busy}, 32'h0);

        // Redirect during WAIT_DATA drops the in-flight burst
        rst = 1;
        tick();
        rst = 0; a_en = 1; a_ready = 1;
        tick();
        chk("rd_req", {31'b0, a_req}, 32'h1);
        tick();
        a_rv = 1; a_rpc = 32'h0000_0043;
        tick();
        chk("rd_busy", {31'b0, a_busy}, 32'h1);
        chk("rd_addr", a_addr,          32'h40);
        a_rv = 0;
        a_rvalid = 1; a_rdata = {32'h0C, 32'h08, 32'h04, 32'h00};
        tick();
        chk("rd_drop_vld",  {31'b0, a_ivld}, 32'h0);
        chk("rd_drop_qcnt", {28'b0, a_qcnt}, 32'h0);
        a_rvalid = 0; a_done = 1;
        tick();
        chk("rd_gap_req", {31'b0, a_req}, 32'h0);
        a_done = 0;
        tick();
        chk("rd_req2",  {31'b0, a_req}, 32'h1);
        chk("rd_addr2", a_addr,         32'h40);
        tick();
        a_rvalid = 1; a_rdata = {32'h4C, 32'h48, 32'h44, 32'h40};
        tick();
        chk("rd_i0", a_instr, 32'h40);
        chk("rd_p0", a_ipc,   32'h40);

        // Redirect coincident with rvalid and a pop while 3 entries are queued
        a_rvalid = 0; a_done = 1;
        tick();
        chk("rc_qcnt3", {28'b0, a_qcnt}, 32'h3);
        a_done = 0; a_ready = 0;
        tick();
        chk("rc_req",  {31'b0, a_req}, 32'h1);
        chk("rc_addr", a_addr,         32'h50);
        tick();
        a_en = 0; a_ready = 1; a_rv = 1; a_rpc = 32'h80;
        a_rvalid = 1; a_rdata = {32'h5C, 32'h58, 32'h54, 32'h50};
        tick();
        chk("rc_qcnt0", {28'b0, a_qcnt}, 32'h0);
        chk("rc_vld",   {31'b0, a_ivld}, 32'h0);
        chk("rc_busy",  {31'b0, a_busy}, 32'h1);
        a_rv = 0; a_rvalid = 0;
        tick();
        chk("rc_qcnt0b", {28'b0, a_qcnt}, 32'h0);
        a_done = 1;
        tick();
        a_done = 0;
        chk("rc_idle", {31'b0, a_busy}, 32'h0);
        chk("rc_addr2", a_addr,         32'h80);

        // FETCH_COUNT = 7: bursts of 4 then 3, lane 3 of the second ignored
        rst = 1;
        tick();
        rst = 0; b_en = 1; b_ready = 1;
        tick();
        chk("f7_req",  {31'b0, b_req}, 32'h1);
        chk("f7_addr", b_addr,         32'h0);
        b_en = 0;
        tick();
        b_rvalid = 1; b_rdata = {32'h0C, 32'h08, 32'h04, 32'h00};
        tick();
        chk("f7_i0", b_instr, 32'h00);
        b_rdata = {32'hDEAD_BEEF, 32'h18, 32'h14, 32'h10};
        tick();
        chk("f7_i1",   b_instr,         32'h04);
        chk("f7_qcnt", {28'b0, b_qcnt}, 32'h6);
        b_rvalid = 0; b_done = 1; b_en = 1;
        tick();
        chk("f7_i2", b_instr, 32'h08);
        b_done = 0;
        tick();
        chk("f7_i3",    b_instr,        32'h0C);
        chk("f7_noreq", {31'b0, b_req}, 32'h0);
        tick();
        chk("f7_i4", b_instr, 32'h10);
        tick();
        chk("f7_i5", b_instr, 32'h14);
        tick();
        chk("f7_i6",    b_instr,        32'h18);
        chk("f7_p6",    b_ipc,          32'h18);
        chk("f7_req2",  {31'b0, b_req}, 32'h1);
        chk("f7_addr2", b_addr,         32'h1C);
        b_en = 0;
        tick();
        chk("f7_empty", {31'b0, b_ivld}, 32'h0);
        chk("f7_qcnt0", {28'b0, b_qcnt}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
